// File: rtl/exu_wb_src_if.sv
// Execute-unit result channel: valid/ready handshake plus destination and data.
// Ports: valid, rd, wdata (source to collector), ready (collector to source).
interface exu_wb_src_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] rd;
  logic [DW-1:0] wdata;

  modport master (
    output valid,
    output rd,
    output wdata,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  wdata,
    output ready
  );
endinterface

// File: rtl/exu_wb_collect.sv
// Write-back collector: five execute-unit channels, 1-entry buffers, one retire/cycle.
// Ports: clk, rst (async active-low); alu/bjp/muldiv/csr/mem channels (exu_wb_src_if.slave);
//   reg_we_o/reg_waddr_o/reg_wdata_o, retire_o, pending_o, pend_rd_mask_o.
// Optional: EXU_WB_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module exu_wb_collect #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  exu_wb_src_if.slave               alu_s,
  exu_wb_src_if.slave               bjp_s,
  exu_wb_src_if.slave               muldiv_s,
  exu_wb_src_if.slave               csr_s,
  exu_wb_src_if.slave               mem_s,
  output logic                      reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
  output logic                      retire_o,
  output logic                      pending_o,
  output logic [31:0]               pend_rd_mask_o
);

  localparam int NS = 5;
  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;

  // Source slots: 0=ALU 1=BJP 2=MULDIV 3=CSR 4=MEM
  logic [NS-1:0] w_in_v;
  logic [AW-1:0] w_in_rd   [NS];
  logic [DW-1:0] w_in_data [NS];

  logic [NS-1:0] r_buf_v;
  logic [AW-1:0] r_buf_rd   [NS];
  logic [DW-1:0] r_buf_data [NS];

  logic [NS-1:0] w_cand_v;
  logic [AW-1:0] w_cand_rd   [NS];
  logic [DW-1:0] w_cand_data [NS];

  logic [NS-1:0] w_gnt;
  logic          w_win_v;
  logic [AW-1:0] w_win_rd;
  logic [DW-1:0] w_win_data;

  logic [NS-1:0] w_buf_v_nxt;
  logic [AW-1:0] w_buf_rd_nxt [NS];
  logic [31:0]   w_mask_nxt;

  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_retire;
  logic [31:0]   r_mask;

  assign w_in_v = {mem_s.valid, csr_s.valid,
                   muldiv_s.valid, bjp_s.valid,
                   alu_s.valid};

  assign w_in_rd[0]   = alu_s.rd;
  assign w_in_rd[1]   = bjp_s.rd;
  assign w_in_rd[2]   = muldiv_s.rd;
  assign w_in_rd[3]   = csr_s.rd;
  assign w_in_rd[4]   = mem_s.rd;
  assign w_in_data[0] = alu_s.wdata;
  assign w_in_data[1] = bjp_s.wdata;
  assign w_in_data[2] = muldiv_s.wdata;
  assign w_in_data[3] = csr_s.wdata;
  assign w_in_data[4] = mem_s.wdata;

  // Ready depends only on buffer state, never on valid.
  assign alu_s.ready    = ~r_buf_v[0];
  assign bjp_s.ready    = ~r_buf_v[1];
  assign muldiv_s.ready = ~r_buf_v[2];
  assign csr_s.ready    = ~r_buf_v[3];
  assign mem_s.ready    = ~r_buf_v[4];

  // A buffered entry shadows its input; an input is only a candidate
  // while its buffer is empty (i.e. it is being accepted this edge).
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      w_cand_v[i]    = r_buf_v[i] | w_in_v[i];
      w_cand_rd[i]   = r_buf_v[i] ? r_buf_rd[i]   : w_in_rd[i];
      w_cand_data[i] = r_buf_v[i] ? r_buf_data[i] : w_in_data[i];
    end
  end

`ifdef EXU_WB_RR_ARB_EN
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;

  // Search runs downward from the slot below the last winner, wrapping
  // 0 -> 4, so the reset value (ALU) hands MEM the first grant.
  always_comb begin
    int idx;
    logic found;
    w_gnt     = '0;
    w_ptr_nxt = r_ptr;
    found     = 1'b0;
    for (int k = 0; k < NS; k++) begin
      idx = (int'(r_ptr) + NS - 1 - k) % NS;
      if (!found && w_cand_v[idx]) begin
        found      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_ptr_nxt  = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  // Fixed priority: MEM > MULDIV > CSR > BJP > ALU.
  always_comb begin
    w_gnt = '0;
    if (w_cand_v[4])      w_gnt[4] = 1'b1;
    else if (w_cand_v[2]) w_gnt[2] = 1'b1;
    else if (w_cand_v[3]) w_gnt[3] = 1'b1;
    else if (w_cand_v[1]) w_gnt[1] = 1'b1;
    else if (w_cand_v[0]) w_gnt[0] = 1'b1;
  end
`endif

  always_comb begin
    w_win_v    = |w_gnt;
    w_win_rd   = '0;
    w_win_data = '0;
    for (int i = 0; i < NS; i++) begin
      if (w_gnt[i]) begin
        w_win_rd   = w_cand_rd[i];
        w_win_data = w_cand_data[i];
      end
    end
  end

  // Next buffer occupancy: a granted slot empties; a losing incoming
  // result drops into its own empty buffer.
  always_comb begin
    w_mask_nxt = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_buf_v[i]) begin
        w_buf_v_nxt[i]  = ~w_gnt[i];
        w_buf_rd_nxt[i] = r_buf_rd[i];
      end else begin
        w_buf_v_nxt[i]  = w_in_v[i] & ~w_gnt[i];
        w_buf_rd_nxt[i] = w_in_rd[i];
      end
      if (w_buf_v_nxt[i] && (w_buf_rd_nxt[i] != '0)) begin
        w_mask_nxt = w_mask_nxt | (32'd1 << w_buf_rd_nxt[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_v <= '0;
      r_mask  <= '0;
      for (int i = 0; i < NS; i++) begin
        r_buf_rd[i]   <= '0;
        r_buf_data[i] <= '0;
      end
    end else begin
      r_buf_v <= w_buf_v_nxt;
      r_mask  <= w_mask_nxt;
      for (int i = 0; i < NS; i++) begin
        if (!r_buf_v[i] && w_in_v[i] && !w_gnt[i]) begin
          r_buf_rd[i]   <= w_in_rd[i];
          r_buf_data[i] <= w_in_data[i];
        end
      end
    end
  end

  // Output stage: x0 winners retire without a register write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_retire <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we     <= w_win_v && (w_win_rd != '0);
      r_retire <= w_win_v;
      if (w_win_v) begin
        r_waddr <= w_win_rd;
        r_wdata <= w_win_data;
      end
    end
  end

  assign reg_we_o       = r_we;
  assign reg_waddr_o    = r_waddr;
  assign reg_wdata_o    = r_wdata;
  assign retire_o       = r_retire;
  assign pending_o      = |r_buf_v;
  assign pend_rd_mask_o = r_mask;

endmodule
